// File: rtl/nonuniform_sar_adc.sv
// nonuniform_sar_adc
//   Clocked successive-approximation quantiser. It compares a real-valued
//   analog sample against a strictly ascending, non-uniform threshold table
//   and resolves one code bit per clock. The result is the number of table
//   entries that are less than or equal to the sampled input.
//
// Parameters
//   NBITS  : output code width. The table holds 2**NBITS-1 thresholds (1..8).
//   THRESH : threshold voltages, strictly ascending.
//   CONT   : 1 = free-running back-to-back conversions (start is ignored).
//
// Ports
//   clk    in   conversion clock; all state updates on its rising edge
//   rst    in   synchronous active-high reset
//   start  in   conversion request, sampled in IDLE only (CONT=0)
//   ain    in   analog input (real)
//   busy   out  high while a conversion is in progress
//   done   out  one-cycle pulse when code is updated
//   code   out  last completed result, held until the next done
//   ovr    out  (NONUNIFORM_SAR_ADC_OVR_EN only) sample beyond the top step
//   udr    out  (NONUNIFORM_SAR_ADC_OVR_EN only) sample below the bottom step
//
// Optional feature macro: NONUNIFORM_SAR_ADC_OVR_EN adds the ovr/udr flags.
`timescale 1ns/1ps
module nonuniform_sar_adc #(
  parameter int  NBITS = 3,
  parameter real THRESH [0:2**NBITS-2] = '{0.5, 1.1, 1.8, 2.5, 3.2, 4.0, 4.7},
  parameter int  CONT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  real              ain,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] code
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
  ,
  output logic             ovr,
  output logic             udr
`endif
);

  localparam int       NT   = 2**NBITS - 1;
  localparam bit [2:0] KTOP = 3'(NBITS - 1);

`ifdef NONUNIFORM_SAR_ADC_OVR_EN
  // Flag limits sit one full end-step beyond the outermost thresholds.
  localparam real OVR_LIM = THRESH[NT-1] + (THRESH[NT-1] - THRESH[NT-2]);
  localparam real UDR_LIM = THRESH[0] - (THRESH[1] - THRESH[0]);
`endif

  // Elaboration-time sanity checks on the configuration.
  if (NBITS < 1 || NBITS > 8) begin : g_bad_nbits
    $error("nonuniform_sar_adc: NBITS must be in 1..8");
  end
  for (genvar i = 1; i < NT; i++) begin : g_chk_order
    if (!(THRESH[i] > THRESH[i-1])) begin : g_bad_order
      $error("nonuniform_sar_adc: THRESH is not strictly ascending");
    end
  end

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state_r, state_n;
  real                sample_r, sample_n;
  logic [NBITS-1:0]   acc_r, acc_n;
  logic [2:0]         k_r, k_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;
  logic [NBITS-1:0]   code_r, code_n;
  logic [NBITS-1:0]   trial;
  logic [NBITS-1:0]   resolved;
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
  logic               ovr_r, ovr_n;
  logic               udr_r, udr_n;
`endif

  // Trial code for the bit under test and the accumulator after the compare.
  // trial is never zero while k_r < NBITS, so THRESH[trial-1] is in range.
  always_comb begin
    trial    = acc_r | (NBITS'(1'b1) << k_r);
    resolved = (sample_r >= THRESH[int'(trial) - 1]) ? trial : acc_r;
  end

  // Next-state and output decode.
  always_comb begin
    state_n  = state_r;
    sample_n = sample_r;
    acc_n    = acc_r;
    k_n      = k_r;
    busy_n   = busy_r;
    done_n   = 1'b0;
    code_n   = code_r;
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
    ovr_n    = ovr_r;
    udr_n    = udr_r;
`endif
    case (state_r)
      IDLE: begin
        busy_n = 1'b0;
        if (CONT != 0 || start) begin
          sample_n = ain;
          acc_n    = '0;
          k_n      = KTOP;
          state_n  = CONV;
          busy_n   = 1'b1;
        end else begin
          state_n  = IDLE;
        end
      end
      CONV: begin
        busy_n = 1'b1;
        acc_n  = resolved;
        if (k_r == 3'd0) begin
          code_n = resolved;
          done_n = 1'b1;
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
          ovr_n  = (sample_r >= OVR_LIM);
          udr_n  = (sample_r <  UDR_LIM);
`endif
          if (CONT != 0) begin
            // Recapture on the resolving edge so conversions run back to back.
            sample_n = ain;
            acc_n    = '0;
            k_n      = KTOP;
          end else begin
            acc_n    = '0;
            state_n  = IDLE;
            busy_n   = 1'b0;
          end
        end else begin
          k_n = k_r - 3'd1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        acc_n   = '0;
        k_n     = 3'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      sample_r <= 0.0;
      acc_r    <= '0;
      k_r      <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      code_r   <= '0;
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
      ovr_r    <= 1'b0;
      udr_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_n;
      sample_r <= sample_n;
      acc_r    <= acc_n;
      k_r      <= k_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
      code_r   <= code_n;
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
      ovr_r    <= ovr_n;
      udr_r    <= udr_n;
`endif
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign code = code_r;
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
  assign ovr  = ovr_r;
  assign udr  = udr_r;
`endif

endmodule

// File: tb/tb_nonuniform_sar_adc.sv
// tb_nonuniform_sar_adc
//   Self-checking bench for nonuniform_sar_adc. One single-shot instance
//   (CONT=0) and one free-running instance (CONT=1) share the 20 MHz clock.
//   Expected codes come from counting table entries <= the applied input.
`timescale 1ns/1ps
module tb_nonuniform_sar_adc;

  localparam int NB = 3;
  localparam int NT = 7;

  real th [0:NT-1] = '{0.5, 1.1, 1.8, 2.5, 3.2, 4.0, 4.7};

  logic          clk = 1'b0;
  logic          rst, rst_c, start;
  real           ain, ain_c;
  logic          busy, done, busy_c, done_c;
  logic [NB-1:0] code, code_c;
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
  logic          ovr, udr, ovr_c, udr_c;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #25 clk = ~clk;

  nonuniform_sar_adc #(.NBITS(NB), .CONT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .ain(ain),
    .busy(busy), .done(done), .code(code)
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
    , .ovr(ovr), .udr(udr)
`endif
  );

  nonuniform_sar_adc #(.NBITS(NB), .CONT(1)) dut_c (
    .clk(clk), .rst(rst_c), .start(1'b0), .ain(ain_c),
    .busy(busy_c), .done(done_c), .code(code_c)
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
    , .ovr(ovr_c), .udr(udr_c)
`endif
  );

  function automatic int ref_code(input real x);
    int n = 0;
    for (int i = 0; i < NT; i++) begin
      if (x >= th[i]) n++;
    end
    return n;
  endfunction

  function automatic logic ref_ovr(input real x);
    return (x >= th[NT-1] + (th[NT-1] - th[NT-2]));
  endfunction

  function automatic logic ref_udr(input real x);
    return (x < th[0] - (th[1] - th[0]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then check busy/done timing and the resulting code.
  task automatic conv_once(input real v, input string tag);
    int exp;
    exp   = ref_code(v);
    ain   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
      chk({tag, "_done_lo"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done"},     32'(done), 32'd1);
    chk({tag, "_code"},     32'(code), 32'(exp));
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
    chk({tag, "_ovr"}, 32'(ovr), 32'(ref_ovr(v)));
    chk({tag, "_udr"}, 32'(udr), 32'(ref_udr(v)));
`endif
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_code_held"},  32'(code), 32'(exp));
  endtask

  real vals [0:299];

  initial begin
    int   nd;
    int   ec;
    logic [7:0] seen;
    real  v;

    // Reset and idle
    rst = 1'b1; rst_c = 1'b1; start = 1'b0; ain = 0.0; ain_c = 0.0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_code", 32'(code), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_cont_busy", 32'(busy_c), 32'd0);
    end

    // Directed single conversions and threshold boundaries
    conv_once(0.3, "c_0p3");
    conv_once(0.5, "c_0p5");
    conv_once(2.0, "c_2p0");
    conv_once(4.0, "c_4p0");
    conv_once(5.0, "c_5p0");
    conv_once(1.8, "c_1p8");
    conv_once(1.7999, "c_1p7999");
`ifdef NONUNIFORM_SAR_ADC_OVR_EN
    conv_once(5.5, "c_ovr");
    conv_once(-0.2, "c_udr");
`endif

    // Input change after capture has no effect
    ain = 0.3; start = 1'b1;
    tick();
    start = 1'b0; ain = 5.0;
    tick(); tick(); tick();
    chk("stab_done", 32'(done), 32'd1);
    chk("stab_code", 32'(code), 32'd0);

    // start during CONV is ignored: exactly one done
    ain = 2.5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) nd++;
      if (i == 0) chk("ign_done_at3", 32'(done), 32'd1);
    end
    chk("ign_done_count", 32'(nd), 32'd1);
    chk("ign_code", 32'(code), 32'(ref_code(2.5)));

    // start in the done cycle: second done four cycles after the first
    ain = 1.1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_code1", 32'(code), 32'(ref_code(1.1)));
    ain = 3.2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_gap", 32'(done), 32'd0);
    tick(); tick();
    chk("b2b_done_early", 32'(done), 32'd0);
    tick();
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_code2", 32'(code), 32'(ref_code(3.2)));
    tick();

    // Reset mid-conversion
    conv_once(5.0, "pre_rst");
    ain = 2.0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_code", 32'(code), 32'd0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done !== 1'b0) nd++;
    end
    chk("mid_rst_no_done", 32'(nd), 32'd0);
    conv_once(2.0, "post_rst");

    // Randomised single conversions across and beyond the table range
    for (int i = 0; i < 20; i++) begin
      v = real'($urandom_range(0, 6000)) / 1000.0 - 0.5;
      conv_once(v, "rand");
    end

    // Free-running mode with a 1 MHz sine on a 20 MHz clock
    seen = 8'h00;
    ain_c = 2.5 + 2.5 * $sin(2.0 * 3.141592653589793 * 1.0e6 * $realtime * 1.0e-9);
    rst_c = 1'b0;
    for (int e = 0; e < 300; e++) begin
      vals[e] = ain_c;
      tick();
      ain_c = 2.5 + 2.5 * $sin(2.0 * 3.141592653589793 * 1.0e6 * $realtime * 1.0e-9);
      chk("cont_busy", 32'(busy_c), 32'd1);
      if (e > 0 && (e % 3) == 0) begin
        ec = ref_code(vals[e-3]);
        chk("cont_done", 32'(done_c), 32'd1);
        chk("cont_code", 32'(code_c), 32'(ec));
        seen[ec] = 1'b1;
      end else begin
        chk("cont_done_lo", 32'(done_c), 32'd0);
      end
    end
    chk("cont_cover", 32'(seen), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nonuniform_sar_adc.md
Name: nonuniform_sar_adc

Overview:
- Clocked successor to the combinational non-uniform-threshold ADC model.
- Quantises an xreal analog input against a parametrised, strictly ascending threshold table.
- Uses a successive-approximation binary search: one comparison per clock.
- Sits between XMODEL analog stimulus/front-end models and digital back-end logic; provides start/busy/done handshake, held output code and optional free-running mode.

Parameters:
- NBITS, 3, output code width; table holds 2**NBITS-1 thresholds.
- THRESH, '{0.5,1.1,1.8,2.5,3.2,4.0,4.7}, real array [0:2**NBITS-2], threshold volts, strictly ascending.
- CONT, 0, 1 = free-running back-to-back conversions; start ignored.

Ports:
- clk  input  1  conversion clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled in IDLE only (CONT=0).
- ain  input  xreal  analog input.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when code is updated.
- code  output  NBITS  last completed result, held until the next done.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, code=0, sample/trial registers cleared. Reset mid-conversion aborts it; no done is issued.
- Transfer function: code = number of THRESH entries <= sampled ain.
  - Input equal to a threshold counts as above it.
  - Below THRESH[0] gives 0; at or above the last entry gives 2**NBITS-1.
- States: IDLE, CONV.
- IDLE:
  - busy=0.
  - If start=1 (CONT=0), or always when CONT=1, at the edge: capture ain as a real into the sample register, set acc=0, bit index k=NBITS-1, go to CONV, busy=1.
- CONV, one bit per edge:
  - Trial t = acc | (1<<k).
  - If sample >= THRESH[t-1], acc = t; otherwise acc is unchanged. Then k = k-1.
  - On the edge resolving k=0: code <= final acc, done=1 for exactly the next cycle.
  - CONT=0: go to IDLE, busy=0.
  - CONT=1: recapture ain on the same edge, stay in CONV with k=NBITS-1, busy stays 1.
- Latency: start sampled at edge E0 gives code valid and done=1 after edge E0+NBITS.
- Throughput: CONT=0 is one conversion per NBITS+1 cycles; start is accepted in the done cycle, since state is IDLE then. CONT=1 is one conversion per NBITS cycles.
- start while busy=1 is ignored (no queueing). start held high in IDLE restarts a conversion each time IDLE is reached.
- ain changes during CONV have no effect; only the captured sample is used.
- code changes only on the done edge or on reset; never shows partial acc values.
- Elaboration check: $error if THRESH is not strictly ascending, or if NBITS < 1 or NBITS > 8.

Optional Feature:
- Macro: NONUNIFORM_SAR_ADC_OVR_EN.
- Defined:
  - Adds output ports ovr (1) and udr (1), updated on the done edge together with code, reset to 0.
  - ovr=1 when sample >= THRESH[2**NBITS-2] + (THRESH[2**NBITS-2] - THRESH[2**NBITS-3]), i.e. more than one top step beyond the last threshold.
  - udr=1 when sample < THRESH[0] - (THRESH[1] - THRESH[0]).
  - code is unchanged by these flags (it still saturates).
- Undefined: ports absent, no extra logic; otherwise identical behaviour.

Test Plan:
- Reset/idle: rst=1 for 2 cycles then 0, no start -> code=0, busy=0, done=0 indefinitely.
- Single conversions, CONT=0, default table: ain = 0.3, 0.5, 2.0, 4.0, 5.0, each with a start pulse -> codes 0, 1, 3, 6, 7. For each, done is high exactly 3 cycles after the start edge and busy is high for 3 cycles.
- Boundary and stability: ain=1.8 -> code 3; ain=1.7999 -> 2. Change ain from 0.3 to 5.0 one cycle after start -> code 0.
- Handshake: start pulsed again in the 2nd CONV cycle -> ignored, only one done. start asserted in the done cycle -> new conversion, second done exactly 4 cycles after the first.
- CONT=1 with a 1 MHz sine (offset 2.5, amplitude 2.5) and a 20 MHz clk -> done every 3 cycles. Each code matches the count of thresholds <= ain at its capture edge; covers all 8 codes.
- Reset mid-conversion: rst=1 during the 2nd CONV cycle -> no done, code=0, busy=0 next cycle; the following start converts correctly. With NONUNIFORM_SAR_ADC_OVR_EN: ain=5.5 -> code 7, ovr=1; ain=-0.2 -> code 0, udr=1.
